csr_sequencer: RTL
==================

# csr_sequencer

Core-side initiator for the machine-level CSR unit: accepts one SYSTEM-class request at a time from the execute stage, converts it into a CSR/exception/MRET operation on the CSR unit's available/busy handshake, and returns rd data or a PC redirect. It also injects pending external/software interrupts at instruction boundaries and escalates CSR access faults into illegal-instruction traps. It sits between the execute stage and the CSR unit.

## Interface
- WATCHDOG_CYCLES, 15: maximum cycles `csr_available` may stay high without a complete busy pulse (used only with the macro below).
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present; held, with all `req_*` stable, until `resp_done`
- req_kind  in  3  000 CSR, 001 MRET, 010 ECALL, 011 EBREAK, 100 illegal, 101 fetch-misaligned; others treated as 100
- req_funct3  in  3  CSR funct3; only [1:0] used (core pre-selects rs1 or zimm into `req_operand`)
- req_csr_addr  in  12  CSR address
- req_operand  in  32  CSR write operand
- req_pc  in  32  PC of the request
- resp_done  out  1  one-cycle completion pulse
- resp_rd_write / resp_rd_value  out  1 / 32  CSR read result to rd
- resp_redirect / resp_target_pc  out  1 / 32  PC redirect
- resp_trap / resp_int  out  1 / 1  trap taken / trap was an interrupt (request not executed)
- csr_available / csr_op / csr_addr_exception / csr_write_value  out  1 / 3 / 12 / 32  to CSR unit
- csr_busy, csr_fault  in  1  from CSR unit
- csr_read_value  in  32  from CSR unit
- csr_ext_int_pending, csr_sw_int_pending  in  1  from CSR unit
- seq_error  out  1  sticky fatal-error flag

## Operation
- States: IDLE, ISSUE, WAIT, GAP, RESP.
- IDLE, `req_valid` high, `resp_done` low: choose operation in priority order:
  - ext interrupt: op 000, addr_exception 0x01B, write_value `req_pc`.
  - sw interrupt: op 000, 0x013, write_value `req_pc`.
  - Otherwise by kind:
    - CSR: op {1, funct3[1:0]}, addr `req_csr_addr`, write_value `req_operand`.
    - MRET: op 001.
    - ECALL: op 000, code 0x00B.
    - EBREAK: 0x003.
    - Illegal: 0x002.
    - Misaligned: 0x000.
    - All exceptions use write_value `req_pc`.
  - Action: drive `csr_available`=1, go to ISSUE.
- ISSUE: hold outputs stable; `csr_busy`=1 → WAIT.
- WAIT: `csr_busy`=0 → result valid; `csr_available`<=0.
  - CSR op and `csr_fault`=1: go to GAP.
  - Non-CSR op and `csr_fault`=1: set `seq_error`, go to RESP.
  - Otherwise: go to RESP.
- GAP: one cycle with available low; reissue as op 000, 0x002, write_value `req_pc`; go to ISSUE.
- RESP: pulse `resp_done`, then go to IDLE.
  - CSR success: `resp_rd_write`=1, rd_value=`csr_read_value`.
  - MRET or exception: `resp_redirect`=1, target=`csr_read_value`, `resp_trap`=1 for exceptions, `resp_int`=1 if interrupt-injected.
- Output reset values:
  - `csr_available`, `resp_*` flags, `seq_error`: 0.
  - All data outputs: 0.
  - `csr_op`: 000.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no response issued.
- Interrupts are sampled only in IDLE. Interrupts arriving later do not preempt an issued operation.

## Timing
- `csr_available` is registered and stays low at least one full cycle between operations, so the CSR unit's started flag clears.
- Nominal sequence, request seen in IDLE at N:
  - N+1: `csr_available` high.
  - N+2: busy high.
  - N+3: busy low, result sampled.
  - N+4: `resp_done`.
- Fault escalation: `resp_done` at N+8.
- IDLE ignores `req_valid` in the `resp_done` cycle. The earliest next issue has available high at N+6.

## Configuration
- CSR_SEQ_WATCHDOG_EN:
  - Defined: counter runs while in ISSUE/WAIT. Reaching WATCHDOG_CYCLES sets `seq_error`, drops available, issues `resp_done` with all flags 0, returns to IDLE.
  - Undefined: no counter; `seq_error` set only by fault on a non-CSR op.

## Structure
- Shared package `csr_pkg`: CSR op encodings, exception codes (0, 2, 3, 11), interrupt cause values 0x01B/0x013, req_kind enum, sequencer state enum.
- One sub-module `csr_watchdog`: down-counter with load/clear/expire, instantiated only under CSR_SEQ_WATCHDOG_EN.

## Test plan
- CSRRS 0x300, operand 0, CSR model returns 0x88 → op 110, `resp_done` at N+4, rd_value 0x88, rd_write 1.
- CSRRW to 0x341 with model fault → GAP, reissue op 000 addr 0x002 write_value=req_pc; `resp_done` at N+8, redirect to 0x10, trap 1.
- `csr_ext_int_pending` and `csr_sw_int_pending` both 1, ECALL pending → exception 0x01B first, resp_int 1, target 0x10.
- MRET, model read_value 0x1234 → op 001, redirect 1, trap 0, target 0x1234.
- reset_n low during WAIT → outputs zero asynchronously, no `resp_done`; next request completes normally.
- With CSR_SEQ_WATCHDOG_EN, model never asserts busy → after 15 cycles `seq_error` 1 and `resp_done` with flags 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR sequencer: CSR op codes, trap causes, request kinds,
// FSM states and the issued-command record with its selection function.
package csr_pkg;

  localparam logic [2:0]  CSR_OP_EXC      = 3'b000;
  localparam logic [2:0]  CSR_OP_MRET     = 3'b001;

  localparam logic [11:0] EXC_MISALIGNED  = 12'h000;
  localparam logic [11:0] EXC_ILLEGAL     = 12'h002;
  localparam logic [11:0] EXC_BREAKPOINT  = 12'h003;
  localparam logic [11:0] EXC_ECALL_M     = 12'h00B;
  localparam logic [11:0] INT_EXT_M       = 12'h01B;
  localparam logic [11:0] INT_SW_M        = 12'h013;

  typedef enum logic [2:0] {
    KIND_CSR        = 3'b000,
    KIND_MRET       = 3'b001,
    KIND_ECALL      = 3'b010,
    KIND_EBREAK     = 3'b011,
    KIND_ILLEGAL    = 3'b100,
    KIND_MISALIGNED = 3'b101
  } req_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP, ST_RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_CSR, CLS_MRET, CLS_EXC, CLS_INT
  } op_class_e;

  typedef struct packed {
    op_class_e   cls;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
  } csr_cmd_t;

  // Pending interrupts win over whatever the request asked for.
  function automatic csr_cmd_t select_cmd(input logic        ext_pend,
                                          input logic        sw_pend,
                                          input logic [2:0]  kind,
                                          input logic [1:0]  funct,
                                          input logic [11:0] addr,
                                          input logic [31:0] operand,
                                          input logic [31:0] pc);
    csr_cmd_t cmd;
    cmd = '{cls: CLS_EXC, op: CSR_OP_EXC, addr: EXC_ILLEGAL, wdata: pc};
    if (ext_pend) begin
      cmd.cls  = CLS_INT;
      cmd.addr = INT_EXT_M;
    end else if (sw_pend) begin
      cmd.cls  = CLS_INT;
      cmd.addr = INT_SW_M;
    end else begin
      case (kind)
        KIND_CSR: begin
          cmd.cls   = CLS_CSR;
          cmd.op    = {1'b1, funct};
          cmd.addr  = addr;
          cmd.wdata = operand;
        end
        KIND_MRET: begin
          cmd.cls   = CLS_MRET;
          cmd.op    = CSR_OP_MRET;
          cmd.addr  = '0;
          cmd.wdata = '0;
        end
        KIND_ECALL:      cmd.addr = EXC_ECALL_M;
        KIND_EBREAK:     cmd.addr = EXC_BREAKPOINT;
        KIND_MISALIGNED: cmd.addr = EXC_MISALIGNED;
        default:         cmd.addr = EXC_ILLEGAL;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/csr_watchdog.sv
// Down-counter that flags a CSR operation whose busy handshake never completes.
// Only instantiated when CSR_SEQ_WATCHDOG_EN is defined.
module csr_watchdog
  #(parameter int CYCLES = 15)
  (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(CYCLES);
    end else if (en_i && count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Fires at the end of the CYCLES-th running cycle; a completing handshake wins.
  assign expire_o = en_i && !clear_i && (count_q == CW'(1));

endmodule

// File: rtl/csr_sequencer.sv
// Execute-stage to CSR-unit sequencer: issues CSR/MRET/trap operations, injects interrupts,
// escalates CSR faults to illegal-instruction traps. Optional CSR_SEQ_WATCHDOG_EN adds a hang watchdog.
module csr_sequencer
  import csr_pkg::*;
  #(parameter int WATCHDOG_CYCLES = 15)
  (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_operand,
  input  logic [31:0] req_pc,
  output logic        resp_done,
  output logic        resp_rd_write,
  output logic [31:0] resp_rd_value,
  output logic        resp_redirect,
  output logic [31:0] resp_target_pc,
  output logic        resp_trap,
  output logic        resp_int,
  output logic        csr_available,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic        csr_busy,
  input  logic        csr_fault,
  input  logic [31:0] csr_read_value,
  input  logic        csr_ext_int_pending,
  input  logic        csr_sw_int_pending,
  output logic        seq_error
);

  seq_state_e  state_q;
  op_class_e   cls_q;
  logic        available_q, resp_done_q, rd_write_q, redirect_q, trap_q, int_q, seq_error_q;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, rd_value_q, target_q;
  csr_cmd_t    cmd_d;
  logic        accept;
  logic        funct3_unused;

  assign cmd_d = select_cmd(csr_ext_int_pending, csr_sw_int_pending, req_kind,
                            req_funct3[1:0], req_csr_addr, req_operand, req_pc);
  assign accept        = (state_q == ST_IDLE) && req_valid && !resp_done_q;
  assign funct3_unused = req_funct3[2];

`ifdef CSR_SEQ_WATCHDOG_EN
  logic wd_expire;

  csr_watchdog #(.CYCLES(WATCHDOG_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (reset_n),
    .load_i   (accept || (state_q == ST_GAP)),
    .clear_i  ((state_q == ST_WAIT) && !csr_busy),
    .en_i     ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
    .expire_o (wd_expire)
  );
`else
  logic [31:0] wd_cfg_unused;
  assign wd_cfg_unused = 32'(WATCHDOG_CYCLES);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_CSR;
      available_q <= 1'b0;
      op_q        <= CSR_OP_EXC;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_done_q <= 1'b0;
      rd_write_q  <= 1'b0;
      rd_value_q  <= '0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
      trap_q      <= 1'b0;
      int_q       <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_done_q <= 1'b0;
          if (accept) begin
            cls_q       <= cmd_d.cls;
            op_q        <= cmd_d.op;
            addr_q      <= cmd_d.addr;
            wdata_q     <= cmd_d.wdata;
            available_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (csr_busy) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!csr_busy) begin
            available_q <= 1'b0;
            if (cls_q == CLS_CSR && csr_fault) begin
              state_q <= ST_GAP;
            end else begin
              if (csr_fault) seq_error_q <= 1'b1;
              resp_done_q <= 1'b1;
              state_q     <= ST_RESP;
              case (cls_q)
                CLS_CSR: begin
                  rd_write_q <= 1'b1;
                  rd_value_q <= csr_read_value;
                end
                CLS_MRET: begin
                  redirect_q <= 1'b1;
                  target_q   <= csr_read_value;
                end
                default: begin
                  redirect_q <= 1'b1;
                  target_q   <= csr_read_value;
                  trap_q     <= 1'b1;
                  int_q      <= (cls_q == CLS_INT);
                end
              endcase
            end
          end
        end
        // Available stayed low for this cycle; retry as an illegal-instruction trap.
        ST_GAP: begin
          cls_q       <= CLS_EXC;
          op_q        <= CSR_OP_EXC;
          addr_q      <= EXC_ILLEGAL;
          wdata_q     <= req_pc;
          available_q <= 1'b1;
          state_q     <= ST_ISSUE;
        end
        ST_RESP: begin
          resp_done_q <= 1'b0;
          rd_write_q  <= 1'b0;
          rd_value_q  <= '0;
          redirect_q  <= 1'b0;
          target_q    <= '0;
          trap_q      <= 1'b0;
          int_q       <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef CSR_SEQ_WATCHDOG_EN
      if (wd_expire) begin
        seq_error_q <= 1'b1;
        available_q <= 1'b0;
        resp_done_q <= 1'b1;
        state_q     <= ST_IDLE;
      end
`endif
    end
  end

  assign resp_done          = resp_done_q;
  assign resp_rd_write      = rd_write_q;
  assign resp_rd_value      = rd_value_q;
  assign resp_redirect      = redirect_q;
  assign resp_target_pc     = target_q;
  assign resp_trap          = trap_q;
  assign resp_int           = int_q;
  assign csr_available      = available_q;
  assign csr_op             = op_q;
  assign csr_addr_exception = addr_q;
  assign csr_write_value    = wdata_q;
  assign seq_error          = seq_error_q;

endmodule
